// File: rtl/mmu_skew_feeder_if.sv
// Handshake and array-side bus between a tile producer, the skew feeder and the MMU.
//   in_valid/in_ready : vector handshake, producer -> feeder
//   in_data/in_wt     : activation and weight vectors, lane i = [i*BIT_WIDTH +: BIT_WIDTH]
//   data_arr/wt_arr   : skewed activations/weights, feeder -> MMU, same packing
//   control           : MMU control line
//   busy/done         : feeder status; done is a one-cycle pulse
// Modports: master = producer/observer side, slave = feeder side.
interface mmu_skew_feeder_if #(
  parameter int LANES     = 4,
  parameter int BIT_WIDTH = 8
);
  logic                       in_valid;
  logic                       in_ready;
  logic [LANES*BIT_WIDTH-1:0] in_data;
  logic [LANES*BIT_WIDTH-1:0] in_wt;
  logic [LANES*BIT_WIDTH-1:0] data_arr;
  logic [LANES*BIT_WIDTH-1:0] wt_arr;
  logic                       control;
  logic                       busy;
  logic                       done;

  modport master (
    output in_valid, in_data, in_wt,
    input  in_ready, data_arr, wt_arr, control, busy, done
  );

  modport slave (
    input  in_valid, in_data, in_wt,
    output in_ready, data_arr, wt_arr, control, busy, done
  );
endinterface

// File: rtl/mmu_skew_feeder.sv
// Input staging for the 4x4 systolic MMU. Buffers one tile of DEPTH activation/weight
// vectors, replays it as a diagonal wavefront (lane i delayed i cycles), appends
// FLUSH_CYCLES zero cycles for array drain and pulses done.
// Ports:
//   clk   : clock, all logic on posedge
//   reset : synchronous, active-low
//   bus   : mmu_skew_feeder_if.slave (handshake in, skewed data/weights and status out)
//
// state  | meaning
// LOAD   | accepting tile vectors into the buffer, in_ready=1
// STREAM | replaying buffer as a skewed wavefront, control=1
// FLUSH  | driving zeros so partial sums drain to acc_out, control=1
// DONE   | single-cycle done pulse, then back to LOAD
module mmu_skew_feeder #(
  parameter int LANES        = 4,
  parameter int BIT_WIDTH    = 8,
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  mmu_skew_feeder_if.slave     bus
);

  localparam int VW          = LANES * BIT_WIDTH;
  localparam int STREAM_LEN  = DEPTH + LANES - 1;
  localparam int STREAM_LAST = STREAM_LEN - 1;
  localparam int CNT_MAX     = (STREAM_LEN > FLUSH_CYCLES) ? STREAM_LEN : FLUSH_CYCLES;
  localparam int CNT_W       = $clog2(CNT_MAX + 1);
  localparam int LD_W        = $clog2(DEPTH + 1);

  localparam logic [1:0] LOAD   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] FLUSH  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]       state;
  logic [LD_W-1:0]  ld_cnt;
  logic [CNT_W-1:0] tmr;
  logic [VW-1:0]    act_buf [DEPTH];
  logic [VW-1:0]    wt_buf  [DEPTH];

  logic [VW-1:0]    data_q;
  logic [VW-1:0]    wt_q;
  logic             control_q;
  logic             busy_q;
  logic             done_q;

  logic             in_ready;
  logic             beat;
  logic             bypass;
  int               t_next;
  logic [VW-1:0]    nxt_data;
  logic [VW-1:0]    nxt_wt;

  assign in_ready = (state == LOAD);
  assign beat     = in_ready & bus.in_valid;

  // tmr counts down through STREAM, so the wavefront index of the cycle being
  // registered is STREAM_LAST - (tmr - 1). From LOAD the next cycle is t=0.
  always_comb begin
    bypass = 1'b0;
    t_next = 0;
    if (state == LOAD) begin
      bypass = 1'b1;
    end else begin
      t_next = STREAM_LAST - (int'(tmr) - 1);
    end
  end

  // Lane i carries row t-i. The final beat lands in the buffer on the same edge
  // that registers t=0, so that row is taken straight from the input.
  always_comb begin
    nxt_data = '0;
    nxt_wt   = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (k == t_next - i) begin
          if (bypass && (k == DEPTH - 1)) begin
            nxt_data[i*BIT_WIDTH +: BIT_WIDTH] = bus.in_data[i*BIT_WIDTH +: BIT_WIDTH];
            nxt_wt[i*BIT_WIDTH +: BIT_WIDTH]   = bus.in_wt[i*BIT_WIDTH +: BIT_WIDTH];
          end else begin
            nxt_data[i*BIT_WIDTH +: BIT_WIDTH] = act_buf[k][i*BIT_WIDTH +: BIT_WIDTH];
            nxt_wt[i*BIT_WIDTH +: BIT_WIDTH]   = wt_buf[k][i*BIT_WIDTH +: BIT_WIDTH];
          end
        end
      end
    end
  end

  // Tile buffer is intentionally not reset.
  always_ff @(posedge clk) begin
    if (beat) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (ld_cnt == LD_W'(k)) begin
          act_buf[k] <= bus.in_data;
          wt_buf[k]  <= bus.in_wt;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= LOAD;
      ld_cnt    <= '0;
      tmr       <= '0;
      data_q    <= '0;
      wt_q      <= '0;
      control_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (beat) begin
            if (ld_cnt == LD_W'(DEPTH - 1)) begin
              ld_cnt    <= '0;
              tmr       <= CNT_W'(STREAM_LAST);
              state     <= STREAM;
              data_q    <= nxt_data;
              wt_q      <= nxt_wt;
              control_q <= 1'b1;
              busy_q    <= 1'b1;
            end else begin
              ld_cnt <= ld_cnt + 1'b1;
            end
          end
        end
        STREAM: begin
          if (tmr == '0) begin
            tmr    <= CNT_W'(FLUSH_CYCLES - 1);
            state  <= FLUSH;
            data_q <= '0;
            wt_q   <= '0;
          end else begin
            tmr    <= tmr - 1'b1;
            data_q <= nxt_data;
            wt_q   <= nxt_wt;
          end
        end
        FLUSH: begin
          if (tmr == '0) begin
            state     <= DONE;
            control_q <= 1'b0;
            done_q    <= 1'b1;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        default: begin
          state  <= LOAD;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.data_arr = data_q;
  assign bus.wt_arr   = wt_q;
  assign bus.control  = control_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule
